// File: rtl/hack_kbd_sequencer.sv
// hack_kbd_sequencer: turns the PS/2 set-2 byte stream into the Hack KBD register value,
//   keeping a stack of held keys so releasing the newest key exposes the previous one.
// Latency: stack, ev_* and hack_code update on the edge that samples the final byte of a
//   sequence (visible next cycle); no backpressure, one byte per cycle is always accepted.
// Ports: clk, rst_n (async active-low); scan_code/got_code byte input strobe;
//   hack_code (16b Hack code of top entry, 0 if empty), key_down (stack non-empty),
//   ev_strobe/ev_break/ev_key (one-cycle make/break event, key {ext,code} held).
// Optional build macro KBD_SHIFT_EN: tracks shift/caps and produces lower-case letters and
//   shifted digit symbols; when undefined letters read 65-90 and digits 48-57.
module hack_kbd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  scan_code,
  input  logic        got_code,
  output logic [15:0] hack_code,
  output logic        key_down,
  output logic        ev_strobe,
  output logic        ev_break,
  output logic [8:0]  ev_key
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_e;

  state_e        state_q;
  logic [2:0]    skip_cnt_q;

  // Held-key stack: index 0 is the oldest entry, cnt_q-1 the newest. Slots at or above
  // cnt_q are kept at zero.
  logic [8:0]    stk_q [DEPTH];
  logic [8:0]    stk_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ev_strobe_q, ev_strobe_d;
  logic          ev_break_q, ev_break_d;
  logic [8:0]    ev_key_q, ev_key_d;

  // Byte classification for the current cycle.
  logic          is_prefix;
  logic          is_drop;
  logic          is_make;
  logic          is_brk;
  logic [8:0]    key;
  logic          mapped;
  logic          hit;
  int            hit_idx;

  logic [8:0]    top_key;
  logic [15:0]   base_code;

  // Base mapping {ext, code} -> Hack value with no modifiers applied (0 = unmapped).
  function automatic logic [15:0] base_map(input logic [8:0] k);
    logic [15:0] v;
    v = 16'd0;
    case (k)
      // letters A..Z
      9'h01C: v = 16'd65;  9'h032: v = 16'd66;  9'h021: v = 16'd67;  9'h023: v = 16'd68;
      9'h024: v = 16'd69;  9'h02B: v = 16'd70;  9'h034: v = 16'd71;  9'h033: v = 16'd72;
      9'h043: v = 16'd73;  9'h03B: v = 16'd74;  9'h042: v = 16'd75;  9'h04B: v = 16'd76;
      9'h03A: v = 16'd77;  9'h031: v = 16'd78;  9'h044: v = 16'd79;  9'h04D: v = 16'd80;
      9'h015: v = 16'd81;  9'h02D: v = 16'd82;  9'h01B: v = 16'd83;  9'h02C: v = 16'd84;
      9'h03C: v = 16'd85;  9'h02A: v = 16'd86;  9'h01D: v = 16'd87;  9'h022: v = 16'd88;
      9'h035: v = 16'd89;  9'h01A: v = 16'd90;
      // digits 0..9
      9'h045: v = 16'd48;  9'h016: v = 16'd49;  9'h01E: v = 16'd50;  9'h026: v = 16'd51;
      9'h025: v = 16'd52;  9'h02E: v = 16'd53;  9'h036: v = 16'd54;  9'h03D: v = 16'd55;
      9'h03E: v = 16'd56;  9'h046: v = 16'd57;
      // space, enter (main and keypad), backspace, escape
      9'h029: v = 16'd32;  9'h05A: v = 16'd128; 9'h15A: v = 16'd128;
      9'h066: v = 16'd129; 9'h076: v = 16'd140;
      // extended cursor block: left, up, right, down
      9'h16B: v = 16'd130; 9'h175: v = 16'd131; 9'h174: v = 16'd132; 9'h172: v = 16'd133;
      // home, end, page up, page down, insert, delete
      9'h16C: v = 16'd134; 9'h169: v = 16'd135; 9'h17D: v = 16'd136; 9'h17A: v = 16'd137;
      9'h170: v = 16'd138; 9'h171: v = 16'd139;
      // F1..F12
      9'h005: v = 16'd141; 9'h006: v = 16'd142; 9'h004: v = 16'd143; 9'h00C: v = 16'd144;
      9'h003: v = 16'd145; 9'h00B: v = 16'd146; 9'h083: v = 16'd147; 9'h00A: v = 16'd148;
      9'h001: v = 16'd149; 9'h009: v = 16'd150; 9'h078: v = 16'd151; 9'h007: v = 16'd152;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Decode the incoming byte against the current parser state.
  always_comb begin
    is_prefix = (scan_code == 8'hE0) || (scan_code == 8'hF0);
    is_drop   = scan_code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    is_make   = 1'b0;
    is_brk    = 1'b0;
    key       = {1'b0, scan_code};
    // A repeated prefix inside a prefix state is swallowed, so only non-prefix bytes
    // can complete a sequence.
    if (got_code && !is_prefix) begin
      case (state_q)
        ST_IDLE:    is_make = !is_drop && (scan_code != 8'hE1);
        ST_EXT: begin
          is_make = 1'b1;
          key     = {1'b1, scan_code};
        end
        ST_BRK:     is_brk = 1'b1;
        ST_EXT_BRK: begin
          is_brk = 1'b1;
          key    = {1'b1, scan_code};
        end
        default: ;
      endcase
    end
    mapped = (base_map(key) != 16'd0);
  end

  // Locate the key in the live part of the stack; entries are unique.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && (i < int'(cnt_q)) && (stk_q[i] == key)) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end
  end

  // Next stack contents and event outputs.
  always_comb begin
    stk_d       = stk_q;
    cnt_d       = cnt_q;
    ev_strobe_d = 1'b0;
    ev_break_d  = ev_break_q;
    ev_key_d    = ev_key_q;
    if (is_make && mapped && !hit) begin
      if (cnt_q == CW'(DEPTH)) begin
        // Full: evict the oldest entry and slide everything down one slot.
        for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
        stk_d[DEPTH-1] = key;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(cnt_q)) stk_d[i] = key;
        end
        cnt_d = cnt_q + CW'(1);
      end
      ev_strobe_d = 1'b1;
      ev_break_d  = 1'b0;
      ev_key_d    = key;
    end else if (is_brk && mapped && hit) begin
      // Remove the entry and compact the newer ones downward.
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= hit_idx) stk_d[i] = stk_q[i+1];
      end
      stk_d[DEPTH-1] = 9'd0;
      cnt_d          = cnt_q - CW'(1);
      ev_strobe_d    = 1'b1;
      ev_break_d     = 1'b1;
      ev_key_d       = key;
    end
  end

  // Parser FSM, stack and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_cnt_q  <= 3'd0;
      cnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= 9'd0;
      ev_strobe_q <= 1'b0;
      ev_break_q  <= 1'b0;
      ev_key_q    <= 9'd0;
    end else begin
      stk_q       <= stk_d;
      cnt_q       <= cnt_d;
      ev_strobe_q <= ev_strobe_d;
      ev_break_q  <= ev_break_d;
      ev_key_q    <= ev_key_d;
      if (got_code) begin
        case (state_q)
          ST_IDLE: begin
            if (scan_code == 8'hE0)      state_q <= ST_EXT;
            else if (scan_code == 8'hF0) state_q <= ST_BRK;
            else if (scan_code == 8'hE1) begin
              // Pause sends E1 followed by seven more bytes with no break form.
              state_q    <= ST_SKIP;
              skip_cnt_q <= 3'd7;
            end
          end
          ST_EXT: begin
            if (scan_code == 8'hF0)      state_q <= ST_EXT_BRK;
            else if (scan_code != 8'hE0) state_q <= ST_IDLE;
          end
          ST_BRK, ST_EXT_BRK: begin
            if (!is_prefix) state_q <= ST_IDLE;
          end
          ST_SKIP: begin
            skip_cnt_q <= skip_cnt_q - 3'd1;
            if (skip_cnt_q == 3'd1) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Newest held key drives the KBD value.
  always_comb begin
    top_key = 9'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(cnt_q) == i + 1) top_key = stk_q[i];
    end
  end

  assign base_code = base_map(top_key);

`ifdef KBD_SHIFT_EN
  logic shift_q, shift_d;
  logic caps_q, caps_d;
  logic caps_held_q, caps_held_d;

  // Shifted digit row: ) ! @ # $ % ^ & * (
  function automatic logic [15:0] shift_digit(input logic [3:0] d);
    logic [15:0] v;
    case (d)
      4'd0: v = 16'd41;  4'd1: v = 16'd33;  4'd2: v = 16'd64;  4'd3: v = 16'd35;
      4'd4: v = 16'd36;  4'd5: v = 16'd37;  4'd6: v = 16'd94;  4'd7: v = 16'd38;
      4'd8: v = 16'd42;  4'd9: v = 16'd40;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Modifier keys are unmapped in the table, so they never reach the stack.
  always_comb begin
    shift_d     = shift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (is_make || is_brk) begin
      if ((key == 9'h012) || (key == 9'h059)) shift_d = is_make;
      if (key == 9'h058) begin
        // Typematic repeats of Caps Lock must not toggle again.
        if (is_make && !caps_held_q) caps_d = !caps_q;
        caps_held_d = is_make;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
    end
  end

  always_comb begin
    hack_code = base_code;
    if ((base_code >= 16'd65) && (base_code <= 16'd90)) begin
      if (!(shift_q ^ caps_q)) hack_code = base_code + 16'd32;
    end else if ((base_code >= 16'd48) && (base_code <= 16'd57) && shift_q) begin
      hack_code = shift_digit(base_code[3:0]);
    end
  end
`else
  assign hack_code = base_code;
`endif

  assign key_down  = (cnt_q != '0);
  assign ev_strobe = ev_strobe_q;
  assign ev_break  = ev_break_q;
  assign ev_key    = ev_key_q;

endmodule
